mips_fetch_unit: RTL and testbench
==================================

# mips_fetch_unit

Parametrised multicycle instruction-fetch unit for the mini-MIPS core: it assembles 32-bit little-endian instructions from a narrow memory bus of configurable width and tolerates wait states through a req/ack handshake. It presents each instruction to the controller through a valid/ready handshake and accepts branch/jump redirects at any cycle. It replaces the fixed four-cycle FETCH1..FETCH4 byte sequencing in the controller.

## Interface
- WIDTH, 8: address/PC width in bits.
- BUSW, 8: memory read-data width; legal values are 8, 16, 32.
- RESET_PC, 0: fetch address loaded on reset.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_req  out  1  read request; held until acknowledged.
- mem_adr  out  WIDTH  byte address of the current beat.
- mem_rdata  in  BUSW  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  beat accepted, data valid this cycle.
- instr  out  32  assembled instruction.
- instr_pc  out  WIDTH  byte address of instr[7:0].
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  controller accepts instr.
- redirect  in  1  load new fetch address.
- redirect_pc  in  WIDTH  new fetch address; low log2(BUSW/8) bits are forced to 0.

## Operation
- BEATS = 32/BUSW. STEP = BUSW/8 bytes per beat.
- The state machine has two states. FETCH drives mem_req=1. HOLD drives instr_valid=1.
- Beat handshake:
  - mem_adr must not change while mem_req=1 and mem_ack=0.
  - On mem_ack, mem_rdata is written into instr bits [beat*BUSW +: BUSW], beat increments, and mem_adr advances by STEP.
  - The last ack (beat = BEATS-1) moves the state to HOLD. mem_req drops next cycle.
- HOLD:
  - instr and instr_pc are held stable until instr_valid && instr_ready.
  - On acceptance, the state goes to FETCH with fetch address instr_pc+4, and beat resets to 0.
- Address arithmetic is modulo 2^WIDTH. 2^WIDTH-4 followed by +4 wraps to 0.
- Redirect has the highest priority and can arrive in any state or beat:
  - fetch address becomes the aligned redirect_pc, beat=0, and the state becomes FETCH.
  - instr_valid deasserts next cycle.
  - Any mem_ack in the same cycle is consumed but its data is discarded.
  - Partial assembly is abandoned.
- Redirect in the same cycle as an accepted instruction: the instruction counts as consumed, and the redirect target is fetched next.
- mem_ack while mem_req=0 is ignored.

## Timing
- Reset values: mem_req=0, mem_adr=RESET_PC, instr=0, instr_pc=RESET_PC, instr_valid=0, beat=0, state=FETCH.
- First mem_req is in the first cycle after reset deasserts.
- Reset mid-fetch or mid-HOLD aborts everything in the same edge; it behaves exactly as power-on reset.
- Zero-wait memory (ack in the same cycle as req):
  - req cycles 0..BEATS-1; instr_valid rises in cycle BEATS.
  - With instr_ready=1, the next req is in cycle BEATS+1. Throughput is one instruction per BEATS+1 cycles.
- Each wait state (mem_ack=0 while mem_req=1) adds exactly one cycle.
- Redirect at edge N: mem_req=1 with mem_adr=target in cycle N+1.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Constants belong in the shared mips_pkg: INSTR_W=32, BEATS/STEP derivation functions, and fetch state encoding FS_FETCH/FS_HOLD.
- One natural sub-module is instr_assembler. It is the 32-bit register with beat-indexed lane write enables (BUSW-lane insert, synchronous clear). It replaces the four separate instruction byte registers.
- Controller glue: FETCH1..4 collapse into a single wait-for-instr_valid state, and the controller drives instr_ready in DECODE. The BEQ/J PC update drives redirect/redirect_pc.

## Test plan
- BUSW=8, zero-wait, memory bytes 0x20,0x01,0x00,0x80 at 0..3 -> mem_adr 0,1,2,3; instr=0x80000120, instr_pc=0, valid in cycle 4; next req adr 4 in cycle 5.
- BUSW=16, 2 wait states per beat -> mem_adr 0 held 3 cycles, then 2 held 3 cycles; instr_valid at cycle 6; lanes halfword little-endian.
- BUSW=32, instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable; mem_req=0 throughout; next fetch at adr 4 after acceptance.
- Redirect to 0x40 during beat 2 with simultaneous mem_ack -> ack data discarded; next cycle mem_req=1, mem_adr=0x40, beat 0; instr_pc later 0x40.
- WIDTH=8, fetch at 0xFC accepted -> next mem_adr 0x00. BUSW=32 with redirect_pc=0x43 -> mem_adr 0x40.
- Reset asserted mid-beat 1 for one cycle -> all outputs at reset values; the fetch restarts at RESET_PC one cycle after reset deasserts.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared mini-MIPS constants: instruction width, fetch bus derivations and
// the fetch state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic {
        FS_FETCH = 1'b0,
        FS_HOLD  = 1'b1
    } fetch_state_e;

    // Number of memory beats needed to assemble one instruction.
    function automatic int fetch_beats(input int busw);
        return INSTR_W / busw;
    endfunction

    // Bytes transferred per memory beat.
    function automatic int fetch_step(input int busw);
        return busw / 8;
    endfunction

endpackage

// File: rtl/mips_fetch_unit_instr_assembler.sv
// 32-bit instruction register built from BUSW-wide lanes; the beat index
// selects which lane a memory beat lands in (lane 0 = instr[BUSW-1:0]).
module mips_fetch_unit_instr_assembler
    import mips_pkg::*;
#(
    parameter int BUSW   = 8,
    parameter int BEAT_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               we_i,
    input  logic [BEAT_W-1:0]  lane_i,
    input  logic [BUSW-1:0]    wdata_i,
    output logic [INSTR_W-1:0] data_o
);

    localparam int BEATS = fetch_beats(BUSW);

    logic [INSTR_W-1:0] data_q;
    logic [INSTR_W-1:0] data_d;

    // Clear wins over a lane write so an abandoned fetch leaves nothing behind.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (we_i) begin
            for (int l = 0; l < BEATS; l++) begin
                if (lane_i == BEAT_W'(l)) begin
                    data_d[l*BUSW +: BUSW] = wdata_i;
                end
            end
        end
    end

    // Instruction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Multicycle instruction fetch: assembles a little-endian 32-bit word from
// BUSW-wide memory beats, then holds it until the controller accepts it.
// A redirect restarts fetching at the aligned target from any state.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               BUSW     = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [WIDTH-1:0]   mem_adr,
    input  logic [BUSW-1:0]    mem_rdata,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] instr,
    output logic [WIDTH-1:0]   instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [WIDTH-1:0]   redirect_pc
);

    localparam int               BEATS      = fetch_beats(BUSW);
    localparam int               STEP       = fetch_step(BUSW);
    localparam int               BEAT_W     = 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WIDTH-1:0] STEP_INC   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] INSTR_INC  = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(STEP - 1);

    fetch_state_e      state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WIDTH-1:0]  adr_q, adr_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic              req_q, req_d;
    logic              beat_ack;
    logic              asm_we;

    // A beat only counts while a request is actually on the bus.
    assign beat_ack = req_q && mem_ack && (state_q == FS_FETCH);
    assign asm_we   = beat_ack && !redirect;

    // Next-state logic; redirect overrides every other transition.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        adr_d   = adr_q;
        pc_d    = pc_q;
        req_d   = req_q;
        if (redirect) begin
            state_d = FS_FETCH;
            beat_d  = '0;
            adr_d   = redirect_pc & ALIGN_MASK;
            pc_d    = redirect_pc & ALIGN_MASK;
            req_d   = 1'b1;
        end else begin
            case (state_q)
                FS_FETCH: begin
                    req_d = 1'b1;
                    if (beat_ack) begin
                        adr_d = adr_q + STEP_INC;
                        if (beat_q == LAST_BEAT) begin
                            state_d = FS_HOLD;
                            beat_d  = '0;
                            req_d   = 1'b0;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                FS_HOLD: begin
                    req_d = 1'b0;
                    if (instr_ready) begin
                        state_d = FS_FETCH;
                        beat_d  = '0;
                        adr_d   = pc_q + INSTR_INC;
                        pc_d    = pc_q + INSTR_INC;
                        req_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = FS_FETCH;
                end
            endcase
        end
    end

    // Control and address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_FETCH;
            beat_q  <= '0;
            adr_q   <= RESET_PC;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            adr_q   <= adr_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
        end
    end

    mips_fetch_unit_instr_assembler #(
        .BUSW   (BUSW),
        .BEAT_W (BEAT_W)
    ) u_asm (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (redirect),
        .we_i    (asm_we),
        .lane_i  (beat_q),
        .wdata_i (mem_rdata),
        .data_o  (instr)
    );

    assign mem_req     = req_q;
    assign mem_adr     = adr_q;
    assign instr_pc    = pc_q;
    assign instr_valid = (state_q == FS_HOLD);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit at BUSW = 8, 16 and 32 sharing one byte memory.
module tb_mips_fetch_unit;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] ins;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected instruction at byte address pc: four bytes, little-endian.
    function automatic item_t mk(input logic [7:0] pc);
        item_t it;
        it.pc  = pc;
        it.ins = {mem[pc + 8'd3], mem[pc + 8'd2], mem[pc + 8'd1], mem[pc]};
        return it;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int         BW    = 8 << k;
        localparam int         ST    = BW / 8;
        localparam int         BEATS = 32 / BW;
        localparam logic [7:0] MASK  = ~8'(ST - 1);

        logic          rst = 1'b1, ack = 1'b0, ready = 1'b0, redir = 1'b0;
        logic [7:0]    tgt = 8'h00;
        logic [BW-1:0] garbage = '0;
        logic          req, valid;
        logic [7:0]    adr, ipc;
        logic [31:0]   ins;
        logic [BW-1:0] rdata;
        item_t         sq[$];
        logic [7:0]    cur_pc = 8'h00;
        int            accepted = 0;

        logic          p_ok = 1'b0, p_rst, p_req, p_ack, p_valid, p_ready, p_redir;
        logic [7:0]    p_adr, p_ipc, p_tgt;
        logic [31:0]   p_ins;

        mips_fetch_unit #(.WIDTH(8), .BUSW(BW), .RESET_PC(8'h00)) dut (
            .clk         (clk),
            .reset       (rst),
            .mem_req     (req),
            .mem_adr     (adr),
            .mem_rdata   (rdata),
            .mem_ack     (ack),
            .instr       (ins),
            .instr_pc    (ipc),
            .instr_valid (valid),
            .instr_ready (ready),
            .redirect    (redir),
            .redirect_pc (tgt)
        );

        // Memory: real data while requested, junk otherwise.
        always_comb begin
            rdata = garbage;
            if (req) begin
                for (int b = 0; b < ST; b++) rdata[b*8 +: 8] = mem[adr + 8'(b)];
            end
        end

        // Drive one cycle of inputs and record which instruction is expected next.
        task automatic drive(input logic r, input logic rdy, input logic rd,
                             input logic [7:0] t, input logic a);
            logic acc;
            @(posedge clk);
            #2;
            acc     = valid && rdy && !r;
            rst     = r;
            ready   = rdy;
            redir   = rd;
            tgt     = t;
            ack     = a;
            garbage = BW'($urandom);
            if (r) begin
                sq.delete();
                cur_pc = 8'h00;
                sq.push_back(mk(cur_pc));
            end else if (rd) begin
                if (!acc && sq.size() > 0) void'(sq.pop_back());
                cur_pc = t & MASK;
                sq.push_back(mk(cur_pc));
            end else if (acc) begin
                cur_pc = cur_pc + 8'd4;
                sq.push_back(mk(cur_pc));
            end
        endtask

        // Scoreboard: every accepted instruction must match the next expected one.
        always @(negedge clk) begin
            if (!rst && valid && ready) begin
                if (sq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty[%0d]: got pc %h with no expected instruction", BW, ipc);
                end else begin
                    chk($sformatf("sb_pc[%0d]", BW), 32'(ipc), 32'(sq[0].pc));
                    chk($sformatf("sb_instr[%0d]", BW), ins, sq[0].ins);
                    void'(sq.pop_front());
                    accepted <= accepted + 1;
                end
            end
        end

        // Cycle-level protocol: what the outputs must be given the previous cycle.
        always @(negedge clk) begin
            if (p_ok) begin
                if (p_rst) begin
                    chk($sformatf("reset_ctl[%0d]", BW), 32'({req, valid}), 32'b00);
                    chk($sformatf("reset_adr[%0d]", BW), 32'({adr, ipc}), 32'h0);
                    chk($sformatf("reset_instr[%0d]", BW), ins, 32'h0);
                end else if (p_redir) begin
                    chk($sformatf("redir_ctl[%0d]", BW), 32'({req, valid}), 32'b10);
                    chk($sformatf("redir_adr[%0d]", BW), 32'(adr), 32'(p_tgt & MASK));
                end else if (p_req && p_ack) begin
                    chk($sformatf("beat_advance[%0d]", BW),
                        32'((req && !valid && adr == p_adr + 8'(ST)) || (valid && !req)), 32'd1);
                end else if (p_req) begin
                    chk($sformatf("wait_hold[%0d]", BW), 32'({req, valid, adr}), 32'({2'b10, p_adr}));
                end else if (p_valid && !p_ready) begin
                    chk($sformatf("hold_ctl[%0d]", BW), 32'({req, valid}), 32'b01);
                    chk($sformatf("hold_instr[%0d]", BW), ins, p_ins);
                    chk($sformatf("hold_pc[%0d]", BW), 32'(ipc), 32'(p_ipc));
                end else if (p_valid) begin
                    chk($sformatf("accept_next[%0d]", BW), 32'({req, valid, adr}),
                        32'({2'b10, p_ipc + 8'd4}));
                end else begin
                    chk($sformatf("fetch_start[%0d]", BW), 32'({req, valid, adr}), 32'({2'b10, p_adr}));
                end
            end
            p_ok    <= 1'b1;
            p_rst   <= rst;
            p_req   <= req;
            p_ack   <= ack;
            p_valid <= valid;
            p_ready <= ready;
            p_redir <= redir;
            p_adr   <= adr;
            p_ipc   <= ipc;
            p_tgt   <= tgt;
            p_ins   <= ins;
        end

        initial begin
            int lat;
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
            // Zero-wait memory: first instruction and steady-state throughput.
            lat = 0;
            while (!valid && lat < 40) begin
                drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
                lat++;
            end
            chk($sformatf("first_latency[%0d]", BW), 32'(lat), 32'(BEATS + 1));
            chk($sformatf("first_instr[%0d]", BW), ins, 32'h80000120);
            chk($sformatf("first_pc[%0d]", BW), 32'(ipc), 32'h0);
            lat = 0;
            do begin
                drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
                lat++;
            end while (!valid && lat < 40);
            chk($sformatf("throughput[%0d]", BW), 32'(lat), 32'(BEATS + 1));
            // Two wait states in front of every beat.
            lat = 0;
            do begin
                drive(1'b0, 1'b0, 1'b0, 8'h00, (lat % 3) == 2);
                lat++;
            end while (!valid && lat < 60);
            chk($sformatf("wait_latency[%0d]", BW), 32'(lat), 32'(3 * BEATS + 1));
            // Controller stalls HOLD for five cycles; stray acks must be ignored.
            repeat (5) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            // Redirect to 0x40 together with an ack two beats into the fetch.
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            drive(1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
            drive(1'b0, 1'b0, 1'b1, 8'h43, 1'b0);
            drive(1'b0, 1'b0, 1'b1, 8'hFC, 1'b0);
            lat = 0;
            while (!valid && lat < 40) begin
                drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
                lat++;
            end
            chk($sformatf("fc_valid[%0d]", BW), 32'(valid), 32'd1);
            chk($sformatf("fc_pc[%0d]", BW), 32'(ipc), 32'hFC);
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            chk($sformatf("wrap_adr[%0d]", BW), 32'(adr), 32'h0);
            // Reset in the middle of the next fetch.
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            // Random traffic.
            repeat (700) begin
                drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 9) < 6);
            end
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("progress[%0d]", BW), 32'(accepted >= 20), 32'd1);
            n_done++;
        end
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h20;
        mem[1] = 8'h01;
        mem[2] = 8'h00;
        mem[3] = 8'h80;
        cyc = 0;
        while (n_done < 3 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (n_done < 3) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d of 3 instances finished, required 3", n_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
